gf_reduce_seq: RTL and testbench



---
 rtl/gf_reduce_seq.sv | 114 +++++++++++
 tb/tb_gf_reduce_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_reduce_seq.sv
// Sequential GF(2^8) reducer: folds a 16-bit carry-less product modulo POLY, one degree per cycle.
// Optional data-dependent early exit is enabled by defining GF_EARLY_EXIT_EN.
`timescale 1ns/1ps

module gf_reduce_seq #(
    parameter logic [8:0]  POLY = 9'h11B,
    parameter int unsigned IN_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_prod,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_res,
    output logic            busy
);

    if (IN_W != 16) begin : g_bad_in_w
        $error("gf_reduce_seq: IN_W must be 16");
    end
    if (POLY[8] != 1'b1) begin : g_bad_poly
        $error("gf_reduce_seq: POLY must be of degree 8");
    end

    typedef enum logic [1:0] {
        StIdle,
        StReduce,
        StDone
    } state_e;

    state_e      r_state, w_state_d;
    logic [15:0] r_work, w_work_d;
    logic [2:0]  r_cnt, w_cnt_d;
    logic [7:0]  r_res, w_res_d;

    logic        w_lead;
    logic [15:0] w_poly_sh;
    logic [15:0] w_step;
    logic        w_last;

    // Bit 8+cnt is the leading coefficient handled this cycle.
    assign w_lead    = r_work[{1'b1, r_cnt}];
    assign w_poly_sh = {7'd0, POLY} << r_cnt;
    assign w_step    = w_lead ? (r_work ^ w_poly_sh) : r_work;

`ifdef GF_EARLY_EXIT_EN
    assign w_last = (r_cnt == 3'd0) || (w_step[15:8] == 8'h00);
`else
    assign w_last = (r_cnt == 3'd0);
`endif

    always_comb begin
        w_state_d = r_state;
        w_work_d  = r_work;
        w_cnt_d   = r_cnt;
        w_res_d   = r_res;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_work_d  = in_prod;
                    w_cnt_d   = 3'd7;
                    w_state_d = StReduce;
`ifdef GF_EARLY_EXIT_EN
                    if (in_prod[15:8] == 8'h00) begin
                        w_cnt_d   = 3'd0;
                        w_res_d   = in_prod[7:0];
                        w_state_d = StDone;
                    end
`endif
                end
            end
            StReduce: begin
                w_work_d = w_step;
                w_cnt_d  = r_cnt - 3'd1;
                if (w_last) begin
                    w_res_d   = w_step[7:0];
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_work  <= 16'h0000;
            r_cnt   <= 3'd0;
            r_res   <= 8'h00;
        end else begin
            r_state <= w_state_d;
            r_work  <= w_work_d;
            r_cnt   <= w_cnt_d;
            r_res   <= w_res_d;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign out_res   = r_res;

    // Held results must not move while the consumer stalls.
    a_hold_res : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_res)));

endmodule

// File: tb/tb_gf_reduce_seq.sv
// Self-checking bench for gf_reduce_seq: directed vectors plus a randomized stream checked
// against a power-table GF(2^8) reference model.
`timescale 1ns/1ps

module tb_gf_reduce_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_prod = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_res;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    gf_reduce_seq #(.POLY(9'h11B), .IN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: result = XOR of (x^k mod P) over every set bit k of the product.
    function automatic logic [7:0] gf_ref(input logic [15:0] p);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = 8'h01;
        acc = 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (p[k]) acc = acc ^ pw;
            pw = pw[7] ? ((pw << 1) ^ 8'h1B) : (pw << 1);
        end
        return acc;
    endfunction

    task automatic send(input logic [15:0] p);
        int n;
        @(posedge clk); #1;
        in_prod  = p;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as 1; 999 means out_valid never came.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 999;
    endtask

    task automatic test_reset;
        n_cmp++;
        if (out_valid !== 1'b0 || out_res !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b res=%h busy=%b rdy=%b want v=0 res=00 busy=0 rdy=1",
                     out_valid, out_res, busy, in_ready);
        end
    endtask

    task automatic test_vector(input string name, input logic [15:0] p, input logic [7:0] want,
                               input int want_lat);
        int lat;
        out_ready = 1'b1;
        send(p);
        wait_done(lat);
        n_cmp++;
        if (out_res !== want) begin
            n_fail++;
            $display("FAIL %s_res: got %h want %h", name, out_res, want);
        end
        if (want_lat > 0) begin
            n_cmp++;
            if (lat !== want_lat) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d want %0d", name, lat, want_lat);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_handoff: got v=%b busy=%b want v=0 busy=0", name, out_valid, busy);
        end
    endtask

    task automatic test_fips;
`ifdef GF_EARLY_EXIT_EN
        test_vector("fips", 16'h2B79, 8'hC1, 0);
`else
        test_vector("fips", 16'h2B79, 8'hC1, 9);
`endif
    endtask

    task automatic test_single_terms;
`ifdef GF_EARLY_EXIT_EN
        test_vector("x8", 16'h0100, 8'h1B, 0);
`else
        test_vector("x8", 16'h0100, 8'h1B, 9);
`endif
        test_vector("x15", 16'h8000, 8'h2F, 9);
    endtask

    task automatic test_passthrough;
`ifdef GF_EARLY_EXIT_EN
        test_vector("pass", 16'h00A5, 8'hA5, 1);
`else
        test_vector("pass", 16'h00A5, 8'hA5, 9);
`endif
    endtask

    task automatic test_backpressure;
        int lat;
        logic [15:0] p;
        logic [7:0]  want;
        p = 16'hC000 | 16'($urandom_range(16'h3FFF));
        want = gf_ref(p);
        out_ready = 1'b0;
        send(p);
        wait_done(lat);
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_res !== want || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b res=%h rdy=%b want v=1 res=%h rdy=0",
                         i, out_valid, out_res, in_ready, want);
            end
            in_valid = i[0];
            in_prod  = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b busy=%b rdy=%b want v=0 busy=0 rdy=1",
                     out_valid, busy, in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_capture: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_midop;
        out_ready = 1'b1;
        send(16'hFFFF);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_res !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got v=%b res=%h busy=%b want v=0 res=00 busy=0",
                     out_valid, out_res, busy);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                n_cmp++;
                n_fail++;
                $display("FAIL midop_ghost: got out_valid=1 want 0");
            end
        end
        test_vector("after_rst", 16'h2B79, 8'hC1, 0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        int sent = 0;
        int rcvd = 0;
        fork
            begin : producer
                bit fired = 0;
                int cyc = 0;
                while (sent < 256 && cyc < 20000) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (fired) in_valid = 1'b0;
                    fired = 0;
                    if (!in_valid && $urandom_range(3) != 0) begin
                        in_prod  = 16'($urandom);
                        in_valid = 1'b1;
                    end
                    @(negedge clk);
                    if (in_valid && in_ready) begin
                        exp_q.push_back(gf_ref(in_prod));
                        sent++;
                        fired = 1;
                    end
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin : consumer
                int cyc = 0;
                logic [7:0] want;
                while (rcvd < 256 && cyc < 20000) begin
                    @(posedge clk); #1;
                    cyc++;
                    out_ready = ($urandom_range(3) != 0);
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL stream_extra[%0d]: got %h want no result", rcvd, out_res);
                        end else begin
                            want = exp_q.pop_front();
                            if (out_res !== want) begin
                                n_fail++;
                                $display("FAIL stream[%0d]: got %h want %h", rcvd, out_res, want);
                            end
                        end
                        rcvd++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (rcvd !== 256 || sent !== 256 || out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: got sent=%0d rcvd=%0d v=%b left=%0d want 256/256/0/0",
                     sent, rcvd, out_valid, exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        #3 rst_n = 1'b1;
        test_fips;
        test_single_terms;
        test_passthrough;
        test_backpressure;
        test_reset_midop;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
